// File: rtl/huffman_freq_counter_pkg.sv
// Shared types and helpers for the Huffman symbol-histogram front end.
// Latency: n/a (package). Backpressure: n/a.
// Contents: FSM state enum, symbol-count helper, saturating increment.
package huffman_pkg;

  typedef enum logic {
    COUNT = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Number of distinct symbols for a given symbol width.
  function automatic int num_sym(input int bit_width);
    return 1 << bit_width;
  endfunction

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/huffman_freq_counter_if.sv
// Symbol input stream, (symbol, frequency) output stream and frame statistics.
// Latency: n/a (interface). Backpressure: sym_ready_i stalls the output stream.
// Modports: slave = histogram block, master = producer/consumer side.
interface huffman_freq_counter_if #(
  parameter int BIT_WIDTH = 8,
  parameter int CNT_WIDTH = 11
);
  logic                 data_en_i;
  logic [BIT_WIDTH-1:0] input_text_i;
  logic                 last_i;
  logic                 busy_o;
  logic                 sym_valid_o;
  logic                 sym_ready_i;
  logic [BIT_WIDTH-1:0] sym_o;
  logic [CNT_WIDTH-1:0] freq_o;
  logic                 sym_last_o;
  logic [BIT_WIDTH:0]   distinct_o;
  logic [CNT_WIDTH-1:0] total_o;
  logic                 overflow_o;
  logic                 frame_done_o;

  modport slave (
    input  data_en_i, input_text_i, last_i, sym_ready_i,
    output busy_o, sym_valid_o, sym_o, freq_o, sym_last_o,
           distinct_o, total_o, overflow_o, frame_done_o
  );

  modport master (
    output data_en_i, input_text_i, last_i, sym_ready_i,
    input  busy_o, sym_valid_o, sym_o, freq_o, sym_last_o,
           distinct_o, total_o, overflow_o, frame_done_o
  );
endinterface

// File: rtl/huffman_freq_counter_table.sv
// NUM_SYM x CNT_WIDTH saturating counter array with increment, read and clear ports.
// Latency: increment/clear take effect next cycle; read and flags are combinational.
// Backpressure: none; caller never increments and clears in the same cycle.
// Ports: inc_* (increment + saturated/was-zero flags), rd_* (read at index), clr_* (clear at index).
module huffman_freq_table
  import huffman_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int CNT_WIDTH = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_en_i,
  input  logic [BIT_WIDTH-1:0] inc_sym_i,
  output logic                 inc_sat_o,
  output logic                 inc_zero_o,
  input  logic [BIT_WIDTH-1:0] rd_idx_i,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  input  logic                 clr_en_i,
  input  logic [BIT_WIDTH-1:0] clr_idx_i
);
  localparam int NUM_SYM = num_sym(BIT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] r_cnt [NUM_SYM];

  // Flags describe the entry before this cycle's increment lands.
  assign inc_sat_o  = (r_cnt[inc_sym_i] == CNT_MAX);
  assign inc_zero_o = (r_cnt[inc_sym_i] == '0);
  assign rd_cnt_o   = r_cnt[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SYM; i++) r_cnt[i] <= '0;
    end else begin
      if (inc_en_i)
        r_cnt[inc_sym_i] <= CNT_WIDTH'(sat_inc(32'(r_cnt[inc_sym_i]), 32'(CNT_MAX)));
      if (clr_en_i)
        r_cnt[clr_idx_i] <= '0;
    end
  end
endmodule

// File: rtl/huffman_freq_counter.sv
// Symbol histogram over a last_i-delimited frame, then drains non-zero (sym, freq) pairs in ascending order.
// Latency: drain starts the cycle after last_i; max_sym+1 cycles minimum plus stall cycles.
// Backpressure: sym_ready_i low holds the current pair; busy_o high means data_en_i must stay low.
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport: input stream, output stream, statistics).
module huffman_freq_counter
  import huffman_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int CNT_WIDTH = 11
) (
  input logic                  clk_i,
  input logic                  rst_i,
  huffman_freq_counter_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [BIT_WIDTH:0]   DIST_ONE = (BIT_WIDTH+1)'(1);
  localparam logic [BIT_WIDTH-1:0] IDX_ONE  = BIT_WIDTH'(1);

  state_e               r_state, w_state_nxt;
  logic [BIT_WIDTH-1:0] r_idx, r_max_sym;
  logic [BIT_WIDTH:0]   r_distinct;
  logic [CNT_WIDTH-1:0] r_total;
  logic                 r_overflow;
  logic                 r_frame_start;

  logic                 w_inc_en, w_inc_sat, w_inc_zero, w_clr_en;
  logic [CNT_WIDTH-1:0] w_rd_cnt;
  logic                 w_valid, w_last, w_xfer;

  huffman_freq_table #(
    .BIT_WIDTH(BIT_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_en_i   (w_inc_en),
    .inc_sym_i  (bus.input_text_i),
    .inc_sat_o  (w_inc_sat),
    .inc_zero_o (w_inc_zero),
    .rd_idx_i   (r_idx),
    .rd_cnt_o   (w_rd_cnt),
    .clr_en_i   (w_clr_en),
    .clr_idx_i  (r_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= COUNT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_inc_en    = 1'b0;
    w_clr_en    = 1'b0;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      COUNT: begin
        w_inc_en = bus.data_en_i;
        if (bus.data_en_i && bus.last_i) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Symbols arriving now are a producer error and are dropped.
        w_valid  = (w_rd_cnt != '0);
        w_last   = w_valid && (r_idx == r_max_sym);
        w_xfer   = w_valid && bus.sym_ready_i;
        w_clr_en = w_xfer;
        if (w_xfer && w_last) w_state_nxt = COUNT;
      end
      default: w_state_nxt = COUNT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx         <= '0;
      r_max_sym     <= '0;
      r_distinct    <= '0;
      r_total       <= '0;
      r_overflow    <= 1'b0;
      r_frame_start <= 1'b1;
    end else begin
      if (w_inc_en) begin
        if (r_frame_start) begin
          // Table is all zero here, so the first symbol is always new and unsaturated.
          r_frame_start <= 1'b0;
          r_total       <= CNT_ONE;
          r_distinct    <= DIST_ONE;
          r_overflow    <= 1'b0;
          r_max_sym     <= bus.input_text_i;
        end else begin
          r_total <= CNT_WIDTH'(sat_inc(32'(r_total), 32'(CNT_MAX)));
          if (w_inc_zero) r_distinct <= r_distinct + DIST_ONE;
          if (w_inc_sat || (r_total == CNT_MAX)) r_overflow <= 1'b1;
          if (bus.input_text_i > r_max_sym) r_max_sym <= bus.input_text_i;
        end
      end
      if (r_state == DRAIN) begin
        if (w_xfer && w_last) begin
          r_idx         <= '0;
          r_frame_start <= 1'b1;
        end else if (!w_valid || w_xfer) begin
          // Skip empty entries one per cycle; stall in place on a refused pair.
          r_idx <= r_idx + IDX_ONE;
        end
      end
    end
  end

  assign bus.busy_o       = (r_state == DRAIN);
  assign bus.sym_valid_o  = w_valid;
  assign bus.sym_o        = (r_state == DRAIN) ? r_idx : '0;
  assign bus.freq_o       = (r_state == DRAIN) ? w_rd_cnt : '0;
  assign bus.sym_last_o   = w_last;
  assign bus.frame_done_o = w_xfer && w_last;
  assign bus.distinct_o   = r_distinct;
  assign bus.total_o      = r_total;
  assign bus.overflow_o   = r_overflow;
endmodule

// File: tb/tb_huffman_freq_counter.sv
// Bench for huffman_freq_counter: table-driven frames, hand sequences, random frames vs a histogram model.
// Latency: drives at posedge+1, samples at posedge+2.
// Backpressure: sym_ready_i driven fixed, stalled or random.
module tb_huffman_freq_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  huffman_freq_counter_if #(.BIT_WIDTH(8), .CNT_WIDTH(11)) bus ();
  huffman_freq_counter_if #(.BIT_WIDTH(8), .CNT_WIDTH(4))  bus4 ();

  huffman_freq_counter #(.BIT_WIDTH(8), .CNT_WIDTH(11)) u_dut  (.clk_i(clk), .rst_i(rst), .bus(bus));
  huffman_freq_counter #(.BIT_WIDTH(8), .CNT_WIDTH(4))  u_dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));

  int checks = 0;
  int errors = 0;

  logic expect_viol = 1'b0;
  always @(negedge clk)
    if (!rst)
      assert (!(bus.busy_o && bus.data_en_i) || expect_viol)
        else $error("protocol: data_en_i asserted while busy_o");

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Stimulus and expectation state shared by the tasks.
  logic [7:0] frame_q[$];
  logic [7:0] q_sym[$];
  int         q_freq[$];
  int         exp_dist, exp_tot, exp_ovf;
  int         last_cyc;
  int         inject_at = 0;

  // Reference: plain histogram of the frame, capped at the counter max.
  task automatic model_frame();
    int cnt [256];
    int cmax = 2047;
    for (int s = 0; s < 256; s++) cnt[s] = 0;
    foreach (frame_q[i]) cnt[frame_q[i]]++;
    q_sym.delete(); q_freq.delete();
    exp_dist = 0; exp_ovf = 0;
    for (int s = 0; s < 256; s++) begin
      if (cnt[s] > 0) begin
        q_sym.push_back(8'(s));
        q_freq.push_back(cnt[s] > cmax ? cmax : cnt[s]);
        exp_dist++;
        if (cnt[s] > cmax) exp_ovf = 1;
      end
    end
    exp_tot = frame_q.size() > cmax ? cmax : frame_q.size();
    if (frame_q.size() > cmax) exp_ovf = 1;
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_q.size(); i++) begin
      @(posedge clk); #1;
      bus.data_en_i    = 1'b1;
      bus.input_text_i = frame_q[i];
      bus.last_i       = (i == frame_q.size() - 1);
    end
    @(posedge clk); #1;
    bus.data_en_i = 1'b0;
    bus.last_i    = 1'b0;
  endtask

  // ready_mode 0: ready high except for 'stall' refused cycles on valid pairs; 1: random ready.
  task automatic drain_frame(input string tag, input int ready_mode, input int stall);
    int  cyc = 0;
    bit  done = 0;
    int  stall_left = stall;
    bit  is_last;
    while (!done && cyc < 1200) begin
      cyc++;
      if (inject_at == cyc) begin
        expect_viol      = 1'b1;
        bus.data_en_i    = 1'b1;
        bus.input_text_i = 8'h10;
      end else begin
        bus.data_en_i = 1'b0;
      end
      if (ready_mode == 1) bus.sym_ready_i = 1'($urandom_range(0, 1));
      else                 bus.sym_ready_i = (stall_left == 0);
      #1;
      check({tag, "_busy"}, bus.busy_o, 1);
      check({tag, "_total_stable"}, bus.total_o, exp_tot);
      check({tag, "_distinct_stable"}, bus.distinct_o, exp_dist);
      if (bus.sym_valid_o) begin
        if (q_sym.size() == 0) begin
          check({tag, "_extra_pair"}, bus.sym_o, 32'hFFFF_FFFF);
          done = 1;
        end else begin
          is_last = (q_sym.size() == 1);
          check({tag, "_sym"}, bus.sym_o, q_sym[0]);
          check({tag, "_freq"}, bus.freq_o, q_freq[0]);
          check({tag, "_last"}, bus.sym_last_o, is_last);
          if (bus.sym_ready_i) begin
            check({tag, "_frame_done"}, bus.frame_done_o, is_last);
            void'(q_sym.pop_front());
            void'(q_freq.pop_front());
            if (is_last) begin
              done     = 1;
              last_cyc = cyc;
            end
          end else if (stall_left > 0) begin
            stall_left--;
          end
        end
      end else begin
        check({tag, "_idle_frame_done"}, bus.frame_done_o, 0);
      end
      @(posedge clk); #1;
      expect_viol   = 1'b0;
      bus.data_en_i = 1'b0;
    end
    if (!done) check({tag, "_drain_timeout"}, 0, 1);
    check({tag, "_missing_pairs"}, q_sym.size(), 0);
    check({tag, "_stall_used"}, stall_left, 0);
    check({tag, "_busy_after"}, bus.busy_o, 0);
    check({tag, "_distinct"}, bus.distinct_o, exp_dist);
    check({tag, "_total"}, bus.total_o, exp_tot);
    check({tag, "_overflow"}, bus.overflow_o, exp_ovf);
    bus.sym_ready_i = 1'b0;
  endtask

  typedef struct packed {
    logic [2:0]      len;
    logic [3:0][7:0] sym;
    logic [2:0]      npair;
    logic [3:0][7:0] esym;
    logic [3:0][7:0] efreq;
    logic [8:0]      edist;
    logic [10:0]     etot;
  } vec_t;

  vec_t tbl [4];

  task automatic load_vec(input vec_t v);
    frame_q.delete(); q_sym.delete(); q_freq.delete();
    for (int j = 0; j < int'(v.len); j++)   frame_q.push_back(v.sym[j]);
    for (int j = 0; j < int'(v.npair); j++) begin
      q_sym.push_back(v.esym[j]);
      q_freq.push_back(int'(v.efreq[j]));
    end
    exp_dist = int'(v.edist);
    exp_tot  = int'(v.etot);
    exp_ovf  = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{len:3'd4, sym:{8'h43, 8'h41, 8'h42, 8'h41}, npair:3'd3,
               esym:{8'h00, 8'h43, 8'h42, 8'h41}, efreq:{8'd0, 8'd1, 8'd1, 8'd2},
               edist:9'd3, etot:11'd4};
    tbl[1] = '{len:3'd1, sym:{8'h00, 8'h00, 8'h00, 8'h07}, npair:3'd1,
               esym:{8'h00, 8'h00, 8'h00, 8'h07}, efreq:{8'd0, 8'd0, 8'd0, 8'd1},
               edist:9'd1, etot:11'd1};
    tbl[2] = '{len:3'd4, sym:{8'h05, 8'h05, 8'h03, 8'h05}, npair:3'd2,
               esym:{8'h00, 8'h00, 8'h05, 8'h03}, efreq:{8'd0, 8'd0, 8'd3, 8'd1},
               edist:9'd2, etot:11'd4};
    tbl[3] = '{len:3'd2, sym:{8'h00, 8'h00, 8'hFF, 8'h00}, npair:3'd2,
               esym:{8'h00, 8'h00, 8'hFF, 8'h00}, efreq:{8'd0, 8'd0, 8'd1, 8'd1},
               edist:9'd2, etot:11'd2};

    bus.data_en_i = 0;  bus.input_text_i = 0;  bus.last_i = 0;  bus.sym_ready_i = 0;
    bus4.data_en_i = 0; bus4.input_text_i = 0; bus4.last_i = 0; bus4.sym_ready_i = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy_o, 0);
    check("rst_valid", bus.sym_valid_o, 0);
    check("rst_sym", bus.sym_o, 0);
    check("rst_freq", bus.freq_o, 0);
    check("rst_last", bus.sym_last_o, 0);
    check("rst_done", bus.frame_done_o, 0);
    check("rst_total", bus.total_o, 0);
    check("rst_distinct", bus.distinct_o, 0);
    check("rst_overflow", bus.overflow_o, 0);
    check("rst4_busy", bus4.busy_o, 0);
    rst = 1'b0;

    // Table-driven frames, consumer always ready.
    for (int i = 0; i < 4; i++) begin
      load_vec(tbl[i]);
      send_frame();
      drain_frame($sformatf("tbl%0d", i), 0, 0);
    end

    // First pair refused for 5 cycles, then the identical sequence.
    load_vec(tbl[0]);
    send_frame();
    drain_frame("stall5", 0, 5);

    // Lone 0xFF: 255 empty entries skipped, pair on the 256th drain cycle.
    frame_q = '{8'hFF};
    model_frame();
    send_frame();
    drain_frame("ff_only", 0, 0);
    check("ff_drain_cycle", last_cyc, 256);
    frame_q = '{8'h00, 8'h00};
    model_frame();
    send_frame();
    drain_frame("after_ff", 0, 0);

    // Symbol pushed during the drain must be dropped.
    frame_q = '{8'h20};
    model_frame();
    send_frame();
    inject_at = 3;
    drain_frame("inject", 0, 0);
    inject_at = 0;
    frame_q = '{8'h30};
    model_frame();
    send_frame();
    drain_frame("post_inject", 0, 0);

    // Reset after the first pair of a drain.
    frame_q = '{8'h01, 8'h02, 8'h03};
    model_frame();
    send_frame();
    begin
      bit got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        bus.sym_ready_i = 1'b1;
        #1;
        if (bus.sym_valid_o) begin
          check("rstmid_first_sym", bus.sym_o, 8'h01);
          got = 1;
        end
        @(posedge clk); #1;
      end
      if (!got) check("rstmid_first_timeout", 0, 1);
    end
    rst = 1'b1;
    bus.sym_ready_i = 1'b0;
    @(posedge clk); #1;
    check("rstmid_valid", bus.sym_valid_o, 0);
    check("rstmid_busy", bus.busy_o, 0);
    check("rstmid_sym", bus.sym_o, 0);
    check("rstmid_freq", bus.freq_o, 0);
    check("rstmid_last", bus.sym_last_o, 0);
    check("rstmid_done", bus.frame_done_o, 0);
    check("rstmid_total", bus.total_o, 0);
    check("rstmid_distinct", bus.distinct_o, 0);
    rst = 1'b0;
    frame_q = '{8'h05};
    model_frame();
    send_frame();
    drain_frame("post_rst", 0, 0);

    // 4-bit counters: 20 copies of 0x00 saturate at 15.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus4.data_en_i = 1'b1; bus4.input_text_i = 8'h00; bus4.last_i = (i == 19);
    end
    @(posedge clk); #1;
    bus4.data_en_i = 1'b0; bus4.last_i = 1'b0; bus4.sym_ready_i = 1'b1;
    #1;
    check("sat_valid", bus4.sym_valid_o, 1);
    check("sat_sym", bus4.sym_o, 0);
    check("sat_freq", bus4.freq_o, 15);
    check("sat_last", bus4.sym_last_o, 1);
    check("sat_done", bus4.frame_done_o, 1);
    check("sat_total", bus4.total_o, 15);
    check("sat_overflow", bus4.overflow_o, 1);
    check("sat_distinct", bus4.distinct_o, 1);
    @(posedge clk); #1;
    bus4.sym_ready_i = 1'b0;
    check("sat_busy_after", bus4.busy_o, 0);

    // Random frames with random backpressure.
    for (int f = 0; f < 8; f++) begin
      int n    = $urandom_range(1, 24);
      int base = $urandom_range(0, 248);
      frame_q.delete();
      for (int k = 0; k < n; k++) begin
        if (f[0]) frame_q.push_back(8'($urandom_range(0, 255)));
        else      frame_q.push_back(8'(base + $urandom_range(0, 7)));
      end
      model_frame();
      send_frame();
      drain_frame($sformatf("rand%0d", f), 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/huffman_freq_counter.md
Name: huffman_freq_counter

Overview:
- Parametrised symbol-histogram front end for the Huffman encoder.
- Accumulates occurrence counts of BIT_WIDTH-bit symbols over a frame delimited by last_i.
- After the frame, streams every non-zero (symbol, frequency) pair in ascending symbol order over a valid/ready handshake.
- Tree builder consumes the stream. Generalises the fixed 8-bit path with configurable symbol and count widths, saturation, backpressure and frame statistics.

Parameters:
- BIT_WIDTH, 8, symbol width; NUM_SYM = 2**BIT_WIDTH is derived, not overridable.
- CNT_WIDTH, 11, width of each frequency counter and of total_o.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- data_en_i  in  1  input symbol valid.
- input_text_i  in  BIT_WIDTH  input symbol.
- last_i  in  1  marks final symbol of frame; sampled only with data_en_i.
- busy_o  out  1  high in DRAIN; producer must not drive data_en_i.
- sym_valid_o  out  1  output pair valid.
- sym_ready_i  in  1  consumer ready.
- sym_o  out  BIT_WIDTH  output symbol.
- freq_o  out  CNT_WIDTH  output frequency.
- sym_last_o  out  1  final pair of frame.
- distinct_o  out  BIT_WIDTH+1  number of distinct symbols in frame.
- total_o  out  CNT_WIDTH  symbols in frame, saturating.
- overflow_o  out  1  some counter or total_o saturated this frame.
- frame_done_o  out  1  one-cycle pulse on the final transfer.

Behaviour:
- Interface decision: one clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset: all counts cleared, state COUNT, all outputs 0. Reset mid-DRAIN aborts the stream with no sym_last_o and no frame_done_o.
- States: COUNT, DRAIN.
- COUNT, per cycle with data_en_i:
  - cnt[s] increments, saturating at 2**CNT_WIDTH-1; saturation sets overflow_o (sticky for the frame).
  - A 0->1 transition increments distinct_o.
  - total_o increments, saturating, and also sets overflow_o when it saturates.
  - max_sym = max(max_sym, s).
- Frame start: the first data_en_i after reset or after a completed drain restarts total_o, distinct_o, overflow_o and max_sym before counting that symbol. Statistics otherwise hold their values.
- data_en_i with last_i in cycle N: that symbol is counted, and state is DRAIN at N+1 with idx=0.
- DRAIN:
  - sym_valid_o = (cnt[idx] != 0); sym_o = idx; freq_o = cnt[idx]; sym_last_o = sym_valid_o && (idx == max_sym).
  - Zero entry: idx increments next cycle (one skip per cycle).
  - Valid && ready: cnt[idx] cleared and idx increments. If sym_last_o, frame_done_o pulses that cycle and state returns to COUNT next cycle.
  - Valid && !ready: sym_o, freq_o and sym_last_o are held stable.
- Table is all zero on return to COUNT; no separate clear phase.
- Drain latency: max_sym+1 cycles minimum plus stall cycles.
- data_en_i during DRAIN is ignored and not counted (protocol violation, flagged by an assertion in the bench).
- idx never wraps: the drain terminates at max_sym, at most NUM_SYM-1.
- A frame always contains at least one symbol, so the drain always emits at least one pair.
- Statistics outputs are stable throughout DRAIN.

Decomposition:
- Package huffman_pkg:
  - state enum {COUNT, DRAIN};
  - function num_sym(BIT_WIDTH);
  - saturating-increment function sat_inc.
- Sub-module huffman_freq_table:
  - NUM_SYM x CNT_WIDTH register array;
  - increment port with saturation flag and zero-before flag;
  - read-at-idx port;
  - clear-at-idx port;
  - synchronous reset clears the whole array.
- Top FSM, idx, max_sym and statistics live in huffman_freq_counter.

Test Plan:
- Frame 0x41,0x42,0x41,0x43 (last on 0x43), sym_ready_i=1 -> pairs (0x41,2), (0x42,1), (0x43,1,last); distinct_o=3, total_o=4, overflow_o=0; frame_done_o with third pair; busy_o low one cycle after.
- Same frame, sym_ready_i low for 5 cycles on the first pair -> (0x41,2) held stable for 5 cycles, then identical sequence; no pair lost or duplicated.
- CNT_WIDTH=4, 20 x 0x00 with last -> single pair (0x00,15,last), total_o=15, overflow_o=1, distinct_o=1.
- Single symbol 0xFF with last -> DRAIN scans 255 zero entries, then (0xFF,1,last) at the 256th drain cycle; next frame of 0x00 x2 -> (0x00,2,last), distinct_o=1, total_o=2 (stats restarted).
- data_en_i pulsed with 0x10 during DRAIN -> not counted; following frame excludes it.
- rst_i asserted mid-DRAIN after the first pair -> no further valid, outputs 0; new frame 0x05 -> only (0x05,1,last), proving the table was cleared.
